// File: rtl/turn_signal_input_conditioner.sv
// Conditions the raw turn-signal lever and hazard button contacts into clean requests:
// synchronize, debounce, hazard press-toggle, per-lever auto-cancel FSM and conflict detection.
module turn_signal_input_conditioner #(
   parameter int unsigned DB_CYCLES      = 1_000_000,
   parameter int unsigned TIMEOUT_CYCLES = 1_500_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic LT_SW,
   input  logic RT_SW,
   input  logic HAZ_BTN,
   output logic LT,
   output logic RT,
   output logic HAZ,
   output logic FAULT
);

   localparam int unsigned DbW  = $clog2(DB_CYCLES + 1);
   localparam int unsigned TmrW = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [DbW-1:0]  DbLast  = DbW'(DB_CYCLES - 1);
   localparam logic [TmrW-1:0] TmrMax  = TmrW'(TIMEOUT_CYCLES);
   localparam logic [TmrW-1:0] TmrLast = TmrW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      StIdle,
      StActive,
      StCancelled
   } lever_state_e;

   // Channel index: 0 = left lever, 1 = right lever, 2 = hazard button.
   logic [2:0]      raw;
   logic [2:0]      sync1_q;
   logic [2:0]      sync2_q;
   logic [2:0]      db_q;
   logic [DbW-1:0]  db_cnt_q [3];
   logic            haz_prev_q;
   logic            fault_now;

   lever_state_e    state_q [2];
   lever_state_e    state_d [2];
   logic [TmrW-1:0] tmr_q   [2];
   logic [TmrW-1:0] tmr_d   [2];

   assign raw       = {HAZ_BTN, RT_SW, LT_SW};
   assign fault_now = db_q[0] & db_q[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= raw;
         sync2_q <= sync1_q;
      end
   end

   // The stable level flips on the DB_CYCLES-th consecutive disagreeing sample; the counter
   // is cleared on the flip, so it never exceeds DB_CYCLES-1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         db_q <= '0;
         for (int i = 0; i < 3; i++) begin
            db_cnt_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (sync2_q[i] == db_q[i]) begin
               db_cnt_q[i] <= '0;
            end else if (db_cnt_q[i] >= DbLast) begin
               db_q[i]     <= sync2_q[i];
               db_cnt_q[i] <= '0;
            end else begin
               db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
            end
         end
      end
   end

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         state_d[i] = state_q[i];
         tmr_d[i]   = tmr_q[i];
         unique case (state_q[i])
            StIdle: begin
               if (db_q[i]) begin
                  state_d[i] = StActive;
                  tmr_d[i]   = '0;
               end
            end
            StActive: begin
               if (!db_q[i]) begin
                  state_d[i] = StIdle;
               end else if (!fault_now && (tmr_q[i] != TmrMax)) begin
                  tmr_d[i] = tmr_q[i] + 1'b1;
                  if (tmr_q[i] == TmrLast) begin
                     state_d[i] = StCancelled;
                  end
               end
            end
            StCancelled: begin
               if (!db_q[i]) begin
                  state_d[i] = StIdle;
               end
            end
            default: begin
               state_d[i] = StIdle;
            end
         endcase
      end
   end

   // Outputs are derived from next-state values so LT/RT/FAULT/HAZ all settle on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            state_q[i] <= StIdle;
            tmr_q[i]   <= '0;
         end
         haz_prev_q <= 1'b0;
         LT         <= 1'b0;
         RT         <= 1'b0;
         HAZ        <= 1'b0;
         FAULT      <= 1'b0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            state_q[i] <= state_d[i];
            tmr_q[i]   <= tmr_d[i];
         end
         haz_prev_q <= db_q[2];
         LT         <= (state_d[0] == StActive) & ~fault_now;
         RT         <= (state_d[1] == StActive) & ~fault_now;
         HAZ        <= HAZ ^ (db_q[2] & ~haz_prev_q);
         FAULT      <= fault_now;
      end
   end

endmodule

// File: tb/tb_turn_signal_input_conditioner.sv
// Randomized and directed stimulus for the turn-signal input conditioner, checked every cycle
// against a behavioural model built from debounce run lengths, lever engage time and press counts.
module tb_turn_signal_input_conditioner;

   localparam int unsigned DB = 4;
   localparam int unsigned TO = 100;

   logic clk = 1'b0;
   logic rst_n;
   logic LT_SW, RT_SW, HAZ_BTN;
   logic LT, RT, HAZ, FAULT;

   int n_checks = 0;
   int n_fail   = 0;
   int cycle    = 0;

   turn_signal_input_conditioner #(
      .DB_CYCLES      (DB),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .LT_SW   (LT_SW),
      .RT_SW   (RT_SW),
      .HAZ_BTN (HAZ_BTN),
      .LT      (LT),
      .RT      (RT),
      .HAZ     (HAZ),
      .FAULT   (FAULT)
   );

   always #5 clk = ~clk;

   // Reference model state
   bit [2:0] m_s1, m_s2, m_db;
   int       m_run [3];
   bit [1:0] m_prev_lvl;
   int       m_age [2];
   bit       m_prev_haz;
   int       m_presses;
   bit       e_lt, e_rt, e_haz, e_fault;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cycle);
      end
   endtask

   function automatic void model_reset();
      m_s1 = '0; m_s2 = '0; m_db = '0; m_prev_lvl = '0; m_prev_haz = 1'b0; m_presses = 0;
      for (int i = 0; i < 3; i++) m_run[i] = 0;
      for (int i = 0; i < 2; i++) m_age[i] = 0;
      e_lt = 1'b0; e_rt = 1'b0; e_haz = 1'b0; e_fault = 1'b0;
   endfunction

   // One rising edge with raw inputs r sampled at that edge.
   function automatic void model_step(bit [2:0] r);
      bit [2:0] lvl;
      bit       fault;
      bit [1:0] req;
      lvl   = m_db;
      fault = lvl[0] && lvl[1];
      // A lever request lasts while held, for TO non-conflicted cycles of engagement.
      for (int i = 0; i < 2; i++) begin
         if (!lvl[i] || !m_prev_lvl[i]) m_age[i] = 0;
         else if (!fault && m_age[i] < int'(TO)) m_age[i]++;
         req[i] = lvl[i] && (m_age[i] < int'(TO)) && !fault;
      end
      m_prev_lvl = lvl[1:0];
      if (lvl[2] && !m_prev_haz) m_presses++;
      m_prev_haz = lvl[2];
      e_lt    = req[0];
      e_rt    = req[1];
      e_haz   = m_presses[0];
      e_fault = fault;
      for (int i = 0; i < 3; i++) begin
         if (m_s2[i] != m_db[i]) m_run[i]++;
         else m_run[i] = 0;
         if (m_run[i] == int'(DB)) begin
            m_db[i]  = ~m_db[i];
            m_run[i] = 0;
         end
      end
      m_s2 = m_s1;
      m_s1 = r;
   endfunction

   task automatic sample_and_check();
      @(posedge clk);
      cycle++;
      model_step({HAZ_BTN, RT_SW, LT_SW});
      #1;
      check_eq("LT", LT, e_lt);
      check_eq("RT", RT, e_rt);
      check_eq("HAZ", HAZ, e_haz);
      check_eq("FAULT", FAULT, e_fault);
   endtask

   task automatic drive_cycle(input bit [2:0] r);
      @(negedge clk);
      {HAZ_BTN, RT_SW, LT_SW} = r;
      sample_and_check();
   endtask

   task automatic do_reset(input int cycles);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_eq("rst_LT", LT, 0);
      check_eq("rst_RT", RT, 0);
      check_eq("rst_HAZ", HAZ, 0);
      check_eq("rst_FAULT", FAULT, 0);
      model_reset();
      repeat (cycles) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      sample_and_check();
   endtask

   initial begin
      int first_lt;
      int lt_high;
      bit [2:0] cur;

      rst_n = 1'b0;
      {HAZ_BTN, RT_SW, LT_SW} = 3'b000;
      model_reset();
      #1;
      check_eq("init_LT", LT, 0);
      check_eq("init_FAULT", FAULT, 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      sample_and_check();

      // Clean left edge: exact latency
      first_lt = 0;
      for (int k = 1; k <= 20; k++) begin
         drive_cycle(3'b001);
         if (LT === 1'b1 && first_lt == 0) first_lt = k;
      end
      check_eq("lt_latency", first_lt, DB + 3);
      repeat (15) drive_cycle(3'b000);

      // Short right-lever pulses must be rejected
      for (int p = 0; p < 5; p++) begin
         repeat (3) drive_cycle(3'b010);
         repeat (3) drive_cycle(3'b000);
      end
      repeat (10) drive_cycle(3'b000);

      // Hazard press-on, press-off
      repeat (10) drive_cycle(3'b100);
      repeat (10) drive_cycle(3'b000);
      repeat (10) drive_cycle(3'b100);
      repeat (10) drive_cycle(3'b000);

      // Auto-cancel after TO cycles, then re-arm on release
      lt_high = 0;
      for (int k = 0; k < 200; k++) begin
         drive_cycle(3'b001);
         if (LT === 1'b1) lt_high++;
      end
      check_eq("lt_timeout_len", lt_high, TO);
      repeat (15) drive_cycle(3'b000);
      repeat (20) drive_cycle(3'b001);
      repeat (15) drive_cycle(3'b000);

      // Both levers: conflict, then release of right resumes left
      repeat (20) drive_cycle(3'b001);
      repeat (60) drive_cycle(3'b011);
      repeat (150) drive_cycle(3'b001);
      repeat (20) drive_cycle(3'b000);

      // Reset with LT and HAZ active, lever still held
      repeat (20) drive_cycle(3'b001);
      repeat (10) drive_cycle(3'b101);
      repeat (5) drive_cycle(3'b001);
      do_reset(3);
      repeat (20) drive_cycle(3'b001);

      // Random blocks with varying bounce density and occasional resets
      cur = 3'b001;
      for (int blk = 0; blk < 20; blk++) begin
         int p;
         case (blk % 4)
            0:       p = 2;
            1:       p = 6;
            2:       p = 30;
            default: p = 250;
         endcase
         for (int c = 0; c < 200; c++) begin
            for (int b = 0; b < 3; b++) begin
               if ($urandom_range(p - 1, 0) == 0) cur[b] = ~cur[b];
            end
            if ($urandom_range(799, 0) == 0) do_reset(2);
            else drive_cycle(cur);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/turn_signal_input_conditioner.md
TURN_SIGNAL_INPUT_CONDITIONER -- requirements
Module: turn_signal_input_conditioner

Interface
REQ-001 Parameter DB_CYCLES, default 1_000_000, debounce stability window in clk cycles (20 ms at 50 MHz).
REQ-002 Parameter TIMEOUT_CYCLES, default 1_500_000_000, turn-signal auto-cancel window in clk cycles (30 s at 50 MHz).
REQ-003 Port clk  input  1  50 MHz system clock; the only clock.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port LT_SW  input  1  raw left-lever contact, asynchronous, bouncing, level (1 = left selected).
REQ-006 Port RT_SW  input  1  raw right-lever contact, asynchronous, bouncing, level.
REQ-007 Port HAZ_BTN  input  1  raw hazard push-button, momentary, bouncing (1 = pressed).
REQ-008 Port LT  output  1  conditioned left-turn request to the light-pattern stage.
REQ-009 Port RT  output  1  conditioned right-turn request.
REQ-010 Port HAZ  output  1  conditioned hazard request.
REQ-011 Port FAULT  output  1  high while both debounced levers are asserted.

Function
REQ-012 Each raw input SHALL pass through its own two-flop synchronizer clocked by clk.
REQ-013 Each synchronized input SHALL have an independent debouncer: stable state updates only after the synchronized value differs from it for DB_CYCLES consecutive cycles; any cycle of agreement clears the counter to 0.
REQ-014 Debounce counter width SHALL be clog2(DB_CYCLES+1); counter saturates, never wraps.
REQ-015 Latency: a clean raw edge held steady SHALL appear on LT/RT (or toggle HAZ) exactly DB_CYCLES+3 rising edges after the first edge sampling the new value (2 sync + DB_CYCLES count + 1 output register).
REQ-016 Glitches shorter than DB_CYCLES cycles (after synchronization) SHALL produce no output change.
REQ-017 Hazard state SHALL toggle on each debounced HAZ_BTN rising edge (press-on/press-off); debounced release has no effect.
REQ-018 Per-lever FSM states: IDLE, ACTIVE, CANCELLED.
REQ-019 IDLE -> ACTIVE when debounced lever = 1; ACTIVE -> IDLE when debounced lever = 0; ACTIVE -> CANCELLED when the lever timer reaches TIMEOUT_CYCLES; CANCELLED -> IDLE only when debounced lever = 0.
REQ-020 Lever timer SHALL clear on entry to ACTIVE, increment each cycle in ACTIVE, saturate at TIMEOUT_CYCLES; width clog2(TIMEOUT_CYCLES+1).
REQ-021 FAULT SHALL be registered and equal debounced-left AND debounced-right.
REQ-022 LT SHALL be 1 iff left FSM = ACTIVE and FAULT = 0; RT likewise for right.
REQ-023 While FAULT = 1, both lever timers SHALL hold (not increment).
REQ-024 HAZ SHALL equal the hazard toggle state, independent of levers and FAULT; LT/RT remain driven per REQ-022 while HAZ = 1 (the downstream stage gives HAZ priority).
REQ-025 Simultaneous debounced lever entry and hazard toggle in one cycle SHALL both take effect in that cycle.
REQ-026 All outputs SHALL be registered; no combinational path from any raw input to any output.

Reset
REQ-027 rst_n = 0 SHALL immediately and asynchronously force LT = 0, RT = 0, HAZ = 0, FAULT = 0.
REQ-028 During reset, synchronizer flops, debounced states, hazard toggle and all counters SHALL be 0 and both FSMs IDLE.
REQ-029 Reset assertion mid-debounce or mid-timeout SHALL discard all progress; after release a held input is re-qualified from zero (full DB_CYCLES+3 latency).
REQ-030 Reset deassertion is synchronized externally; the block needs no extra release logic.

Verification (DB_CYCLES = 4, TIMEOUT_CYCLES = 100)
REQ-031 LT_SW 0->1 held -> LT = 1 exactly 7 cycles later, RT = HAZ = FAULT = 0.
REQ-032 RT_SW pulsed high 3 cycles then low, repeated 5 times -> RT stays 0 throughout.
REQ-033 HAZ_BTN pressed 10 cycles, released, pressed again 10 cycles -> HAZ goes 1 after first press (7 cycles), returns 0 after second press; release edges cause no change.
REQ-034 LT_SW held 200 cycles -> LT = 1 for 100 cycles then 0 while LT_SW still 1; LT_SW released and re-asserted -> LT = 1 again 7 cycles after re-assertion.
REQ-035 LT_SW and RT_SW both held -> FAULT = 1, LT = RT = 0; RT_SW released -> FAULT = 0, LT = 1 with timer resuming from its held value.
REQ-036 rst_n pulsed low with LT = 1 and HAZ = 1 -> all outputs 0 in the same cycle; LT_SW still held -> LT = 1 7 cycles after rst_n rises, HAZ stays 0.
